vx_ahb_mem_arbiter: RTL
=======================

// Module: vx_ahb_mem_arbiter
// PURPOSE
// - Shares one Vortex-style mem request/response port (VX_ahb_adapter front end) among NUM_REQS requesters.
// - Round-robin grant; one transaction in flight (adapter is single-outstanding); response routed to owner.
// - Sits between cache/DMA mem ports and VX_ahb_adapter; also provides a response-timeout watchdog.
// PARAMETERS
// - NUM_REQS      4     number of requesters (>=2)
// - DATA_WIDTH    512   request/response data width
// - ADDR_WIDTH    26    line address width (32 - log2(DATA_WIDTH/8))
// - TAG_WIDTH     8     requester tag width, returned unchanged
// - RSP_TIMEOUT   1024  max cycles waiting for a response (>=2)
// PORTS
// - clk           in   1                    clock
// - reset         in   1                    async, active-low reset
// - up_req_valid  in   NUM_REQS             per-requester request valid
// - up_req_rw     in   NUM_REQS             1=write
// - up_req_byteen in   NUM_REQS*DATA_WIDTH/8  byte enables, packed by requester
// - up_req_addr   in   NUM_REQS*ADDR_WIDTH  line addresses
// - up_req_data   in   NUM_REQS*DATA_WIDTH  write data
// - up_req_tag    in   NUM_REQS*TAG_WIDTH   tags
// - up_req_ready  out  NUM_REQS             one-hot accept
// - up_rsp_valid  out  NUM_REQS             one-hot response valid
// - up_rsp_data   out  DATA_WIDTH           response data (broadcast)
// - up_rsp_tag    out  TAG_WIDTH            latched tag of owner
// - up_rsp_ready  in   NUM_REQS             per-requester response ready
// - dn_req_valid/rw/byteen/addr/data/tag  out  as above (single)  to adapter
// - dn_req_ready  in   1                    adapter accepts
// - dn_rsp_valid  in   1                    adapter response valid
// - dn_rsp_data   in   DATA_WIDTH           adapter response data
// - dn_rsp_ready  out  1                    = up_rsp_ready[owner] in WAIT
// - busy          out  1                    state != IDLE
// - err_timeout   out  1                    sticky watchdog flag
// BEHAVIOUR
// - Reset (async, reset==0): state=IDLE, rr_ptr=0, owner=0, latched fields=0, wdog=0, err_timeout=0; all outputs 0.
// - FSM: IDLE -> ISSUE -> WAIT -> IDLE.
// - IDLE: grant = first valid requester at/after rr_ptr (wrap NUM_REQS-1 -> 0); up_req_ready[grant]=1
//   same cycle only when some valid; on accept latch rw/byteen/addr/data/tag, owner=grant, go ISSUE.
// - ISSUE: dn_req_valid=1 with latched fields, held stable until dn_req_ready; then WAIT, wdog=0.
// - WAIT: up_rsp_valid[owner]=dn_rsp_valid; up_rsp_data=dn_rsp_data; up_rsp_tag=latched tag;
//   dn_rsp_ready=up_rsp_ready[owner]. Handshake -> IDLE, rr_ptr=(owner+1) mod NUM_REQS.
// - Reads and writes both expect exactly one response.
// - Watchdog: wdog increments each WAIT cycle without handshake; at wdog==RSP_TIMEOUT-1 set
//   err_timeout, return IDLE, advance rr_ptr, no response issued. Handshake on that cycle wins.
// - Latency: accept at IDLE cycle t, dn_req_valid at t+1 earliest; next grant earliest cycle after rsp handshake.
// - up_req_ready=0 in ISSUE/WAIT; requesters hold valid. Non-granted requests never dropped; starvation-free
//   (every valid requester granted within NUM_REQS transactions).
// - Reset mid-transaction aborts it; no response delivered afterwards.
// - up_rsp_valid bits other than owner are always 0; at most one up_req_ready bit set.
// STRUCTURE
// - Package vx_ahb_arb_pkg: state enum {IDLE,ISSUE,WAIT}, IDX_W=$clog2(NUM_REQS) helper.
// - Sub-module vx_rr_arbiter (comb): inputs valid vector + rr_ptr, outputs one-hot grant + index, any_valid.
// - Top holds FSM, request latch, owner, rr_ptr, watchdog counter.
// TESTING
// - Single read: req0 valid addr=0x100 tag=0x5A -> dn_req addr=0x100 one cycle later; rsp data D -> up_rsp_valid[0], tag 0x5A.
// - All 4 valid continuously -> grant order 0,1,2,3,0; each gets exactly one response.
// - Backpressure: dn_req_ready low 5 cycles -> dn_req fields stable; up_rsp_ready[owner] low 3 cycles -> dn_rsp_ready low, no loss.
// - Write req2 rw=1 byteen=all-ones -> dn_req_rw=1, data/byteen match; response returned to req2 only.
// - Timeout RSP_TIMEOUT=16, no dn_rsp_valid -> err_timeout=1 after 16 WAIT cycles, IDLE, next requester granted.
// - Reset asserted in WAIT -> outputs 0 immediately, rr_ptr=0, later response not routed.

Source files
------------

// File: rtl/vx_ahb_arb_pkg.sv
// Shared types for the AHB memory-port arbiter.
// - arb_state_e : arbiter FSM states
// - idx_w()     : width of a requester index (at least 1 bit)
package vx_ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   valid     in   NUM_REQS  request vector
//   rr_ptr    in   IDX_W     highest-priority requester this round
//   grant     out  NUM_REQS  one-hot grant (zero when nothing valid)
//   grant_idx out  IDX_W     index of the granted requester
//   any_valid out  1         at least one request pending
module vx_rr_arbiter
  import vx_ahb_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDX_W = idx_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_valid
);

  logic [IDX_W:0]   k;
  logic [IDX_W-1:0] idx;

  // Scan requesters starting at rr_ptr, wrapping past NUM_REQS-1; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    k         = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      k = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (k >= (IDX_W+1)'(NUM_REQS)) k = k - (IDX_W+1)'(NUM_REQS);
      idx = k[IDX_W-1:0];
      if (!any_valid && valid[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_ahb_mem_arbiter.sv
// Shares one single-outstanding mem port (AHB adapter front end) among
// NUM_REQS requesters with round-robin grant and a response watchdog.
// Ports:
//   clk, reset          clock, async active-low reset
//   up_req_*            packed per-requester requests; up_req_ready one-hot
//   up_rsp_valid/ready  per-requester response handshake (only owner bit set)
//   up_rsp_data/tag     response data (broadcast) and owner's latched tag
//   dn_req_*            single request to the adapter, held until dn_req_ready
//   dn_rsp_*            adapter response handshake
//   busy                transaction in progress
//   err_timeout         sticky: a response never arrived within RSP_TIMEOUT cycles
module vx_ahb_mem_arbiter
  import vx_ahb_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int ADDR_WIDTH  = 26,
  parameter int TAG_WIDTH   = 8,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            up_req_valid,
  input  logic [NUM_REQS-1:0]            up_req_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] up_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] up_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] up_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  up_req_tag,
  output logic [NUM_REQS-1:0]            up_req_ready,
  output logic [NUM_REQS-1:0]            up_rsp_valid,
  output logic [DATA_WIDTH-1:0]          up_rsp_data,
  output logic [TAG_WIDTH-1:0]           up_rsp_tag,
  input  logic [NUM_REQS-1:0]            up_rsp_ready,
  output logic                           dn_req_valid,
  output logic                           dn_req_rw,
  output logic [DATA_WIDTH/8-1:0]        dn_req_byteen,
  output logic [ADDR_WIDTH-1:0]          dn_req_addr,
  output logic [DATA_WIDTH-1:0]          dn_req_data,
  output logic [TAG_WIDTH-1:0]           dn_req_tag,
  input  logic                           dn_req_ready,
  input  logic                           dn_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          dn_rsp_data,
  output logic                           dn_rsp_ready,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int IDX_W = idx_w(NUM_REQS);
  localparam int BEW   = DATA_WIDTH / 8;
  localparam int WD_W  = $clog2(RSP_TIMEOUT);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr, owner, gnt_idx, owner_nxt;
  logic [NUM_REQS-1:0] grant;
  logic             any_valid;
  logic [WD_W-1:0]  wdog;
  logic             in_wait, rsp_hs, busy_q, dn_req_valid_q;

  logic                  lat_rw;
  logic [BEW-1:0]        lat_byteen;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [TAG_WIDTH-1:0]  lat_tag;

  logic [BEW-1:0]        req_byteen_a [NUM_REQS];
  logic [ADDR_WIDTH-1:0] req_addr_a   [NUM_REQS];
  logic [DATA_WIDTH-1:0] req_data_a   [NUM_REQS];
  logic [TAG_WIDTH-1:0]  req_tag_a    [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign req_byteen_a[g] = up_req_byteen[g*BEW +: BEW];
    assign req_addr_a[g]   = up_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_a[g]   = up_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign req_tag_a[g]    = up_req_tag[g*TAG_WIDTH +: TAG_WIDTH];
  end

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
    .valid     (up_req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .any_valid (any_valid)
  );

  assign in_wait   = (state == WAIT);
  assign rsp_hs    = in_wait && dn_rsp_valid && up_rsp_ready[owner];
  assign owner_nxt = (owner == IDX_W'(NUM_REQS-1)) ? '0 : owner + 1'b1;

  // Ready is combinational so a request is accepted in the same IDLE cycle;
  // gated by reset so nothing looks accepted while the block is held in reset.
  assign up_req_ready  = (state == IDLE && reset) ? grant : '0;
  assign up_rsp_valid  = (in_wait && dn_rsp_valid) ? (NUM_REQS'(1) << owner) : '0;
  assign up_rsp_data   = in_wait ? dn_rsp_data : '0;
  assign up_rsp_tag    = lat_tag;
  assign dn_rsp_ready  = in_wait && up_rsp_ready[owner];

  assign dn_req_valid  = dn_req_valid_q;
  assign dn_req_rw     = lat_rw;
  assign dn_req_byteen = lat_byteen;
  assign dn_req_addr   = lat_addr;
  assign dn_req_data   = lat_data;
  assign dn_req_tag    = lat_tag;
  assign busy          = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      wdog           <= '0;
      err_timeout    <= 1'b0;
      busy_q         <= 1'b0;
      dn_req_valid_q <= 1'b0;
      lat_rw         <= 1'b0;
      lat_byteen     <= '0;
      lat_addr       <= '0;
      lat_data       <= '0;
      lat_tag        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            lat_rw         <= up_req_rw[gnt_idx];
            lat_byteen     <= req_byteen_a[gnt_idx];
            lat_addr       <= req_addr_a[gnt_idx];
            lat_data       <= req_data_a[gnt_idx];
            lat_tag        <= req_tag_a[gnt_idx];
            owner          <= gnt_idx;
            dn_req_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (dn_req_ready) begin
            dn_req_valid_q <= 1'b0;
            wdog           <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          // A handshake on the final watchdog cycle still completes normally.
          if (rsp_hs) begin
            rr_ptr <= owner_nxt;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (wdog == WD_W'(RSP_TIMEOUT-1)) begin
            err_timeout <= 1'b1;
            rr_ptr      <= owner_nxt;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          busy_q         <= 1'b0;
          dn_req_valid_q <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
